// File: rtl/tick_pwm.sv
// rtl/tick_pwm.sv - tick-driven PWM generator with shadowed period/duty
//
// Purpose: advances a period counter once per enable tick from the divider,
//   and drives a glitch-free PWM output. Period and duty are loaded into
//   shadow registers and only take effect at a period boundary or at start.
// Optional: define TICK_PWM_SYNC_EN to pass tick through a 2-flop
//   synchronizer with rising-edge detect (one count per tick rise).
// Ports:
//   clk       system clock, posedge
//   rst_b     asynchronous active-low reset
//   tick      count enable from divider
//   en        run enable (level)
//   ld        load strobe for period_in/duty_in into shadow registers
//   period_in period length in ticks
//   duty_in   high time in ticks
//   pwm       registered PWM output
//   cyc_done  one-clk pulse on the tick that wraps the counter
//   busy      high while running
module tick_pwm #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         tick,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] duty_in,
  output logic         pwm,
  output logic         cyc_done,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, nxt_state;
  logic [W-1:0] cnt, nxt_cnt;
  logic [W-1:0] shd_per, shd_duty;
  logic [W-1:0] act_per, act_duty, nxt_per, nxt_duty;
  logic         nxt_done;
  logic         t_use;

`ifdef TICK_PWM_SYNC_EN
  // sync[0..1] is the synchronizer, sync[2] the edge-detect history.
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) sync <= '0;
    else        sync <= {sync[1:0], tick};
  end

  assign t_use = sync[1] & ~sync[2];
`else
  assign t_use = tick;
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_per   = act_per;
    nxt_duty  = act_duty;
    nxt_done  = 1'b0;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (en) begin
          // Old shadow values are taken even if ld fires on this same edge.
          nxt_state = RUN;
          nxt_per   = shd_per;
          nxt_duty  = shd_duty;
        end
      end
      RUN: begin
        if (!en) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else if (t_use) begin
          if (act_per == '0) begin
            // Parked: keep polling the shadow so a later nonzero load starts it.
            nxt_cnt  = '0;
            nxt_per  = shd_per;
            nxt_duty = shd_duty;
          end else if (cnt == act_per - 1'b1) begin
            nxt_cnt  = '0;
            nxt_done = 1'b1;
            nxt_per  = shd_per;
            nxt_duty = shd_duty;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      cnt      <= '0;
      shd_per  <= '0;
      shd_duty <= '0;
      act_per  <= '0;
      act_duty <= '0;
      pwm      <= 1'b0;
      cyc_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      act_per  <= nxt_per;
      act_duty <= nxt_duty;
      cyc_done <= nxt_done;
      busy     <= (nxt_state == RUN);
      // Built from next-state values so pwm has no lag relative to cnt.
      pwm      <= (nxt_state == RUN) && (nxt_per != '0) && (nxt_cnt < nxt_duty);
      if (ld) begin
        shd_per  <= period_in;
        shd_duty <= duty_in;
      end
    end
  end

endmodule
